// File: rtl/bcd_pkg.sv
// Shared constants for the BCD counter: digit width, largest digit value and
// the run/stop state encoding, plus a nibble validity helper.
package bcd_pkg;

  localparam int                 BCD_W   = 4;
  localparam logic [BCD_W-1:0]   BCD_MAX = 4'd9;

  localparam logic STOP = 1'b0;
  localparam logic RUN  = 1'b1;

  typedef enum logic {
    ST_STOP = STOP,
    ST_RUN  = RUN
  } state_e;

  function automatic logic bcd_ok(input logic [BCD_W-1:0] nib);
    return (nib <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register. Steps when enabled and the carry/borrow from the
// lower digit is present; o_cout signals that this digit rolls over too.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [BCD_W-1:0] i_load_val,
  input  logic             i_step,
  input  logic             i_dir,
  input  logic             i_cin,
  output logic             o_cout,
  output logic [BCD_W-1:0] o_digit
);

  logic [BCD_W-1:0] r_digit;
  logic [BCD_W-1:0] w_next;
  logic             w_edge;

  // Digit sits at the rollover point for the current direction.
  assign w_edge = i_dir ? (r_digit == '0) : (r_digit == BCD_MAX);
  assign o_cout = i_cin & w_edge;

  always_comb begin
    w_next = r_digit;
    if (i_dir) begin
      w_next = w_edge ? BCD_MAX : (r_digit - 4'd1);
    end else begin
      w_next = w_edge ? '0 : (r_digit + 4'd1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_digit <= '0;
    end else if (i_clear) begin
      r_digit <= '0;
    end else if (i_load) begin
      r_digit <= i_load_val;
    end else if (i_step && i_cin) begin
      r_digit <= w_next;
    end
  end

  assign o_digit = r_digit;

endmodule

// File: rtl/bcd_counter_n.sv
// NDIGITS-digit BCD up/down counter with run/stop FSM and prescaled tick.
// Define BCD_COUNTER_SATURATE_EN to hold at 9..9 / 0..0 instead of wrapping.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter int PRESCALE = 50000000
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   run_tgl,
  input  logic                   dir_tgl,
  input  logic                   clear,
  input  logic                   load,
  input  logic [4*NDIGITS-1:0]   load_value,
  output logic [4*NDIGITS-1:0]   digits,
  output logic                   running,
  output logic                   direction,
  output logic                   tick,
  output logic                   wrap,
  output logic                   load_err
);

  localparam int             PW   = $clog2(PRESCALE);
  localparam logic [PW-1:0]  PMAX = PW'(PRESCALE - 1);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [PW-1:0]   r_presc;
  logic            r_dir;
  logic            r_load_err;
  logic            w_load_valid;
  logic            w_load_ok;
  logic            w_presc_done;
  logic            w_tick;
  logic            w_step;
  logic [NDIGITS:0] w_carry;

  // FSM: state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_STOP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    if (run_tgl) begin
      case (r_state)
        ST_STOP: w_state_nxt = ST_RUN;
        ST_RUN:  w_state_nxt = ST_STOP;
        default: w_state_nxt = ST_STOP;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    running = (r_state == ST_RUN);
  end

  always_comb begin
    w_load_valid = 1'b1;
    for (int d = 0; d < NDIGITS; d++) begin
      if (!bcd_ok(load_value[d*BCD_W +: BCD_W])) begin
        w_load_valid = 1'b0;
      end
    end
  end

  assign w_load_ok    = load & ~clear & w_load_valid;
  assign w_presc_done = (r_state == ST_RUN) && (r_presc == PMAX);
  // clear and load outrank the count step; the suppressed tick is not shown.
  assign w_tick       = w_presc_done & ~clear & ~load;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_presc <= '0;
    end else if ((r_state != ST_RUN) || (w_state_nxt != ST_RUN) ||
                 clear || load || w_presc_done) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dir      <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      if (dir_tgl) begin
        r_dir <= ~r_dir;
      end
      r_load_err <= load & ~clear & ~w_load_valid;
    end
  end

  assign w_carry[0] = 1'b1;

`ifdef BCD_COUNTER_SATURATE_EN
  // Carry out of the top digit means the whole word sits at its limit.
  assign w_step = w_tick & ~w_carry[NDIGITS];
  assign wrap   = 1'b0;
`else
  assign w_step = w_tick;
  assign wrap   = w_tick & w_carry[NDIGITS];
`endif

  for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .i_clk      (CLK),
      .i_rst_n    (RST_N),
      .i_clear    (clear),
      .i_load     (w_load_ok),
      .i_load_val (load_value[g*BCD_W +: BCD_W]),
      .i_step     (w_step),
      .i_dir      (r_dir),
      .i_cin      (w_carry[g]),
      .o_cout     (w_carry[g+1]),
      .o_digit    (digits[g*BCD_W +: BCD_W])
    );
  end

  assign tick      = w_tick;
  assign direction = r_dir;
  assign load_err  = r_load_err;

endmodule
